inst_capture: RTL and testbench
===============================

// Module: inst_capture
// PURPOSE
//  Upstream front end of the nexys3 sequencer core. Synchronises the btnS push-button
//  and the 8 instruction switches, then debounces btnS. Emits exactly one single-cycle
//  inst_vld per clean press, with inst_wd holding the switch word sampled at that press.
//  The core decodes inst_wd[7:6] (00 PUSH, 01 ADD, 10 MULT, 11 SEND); this block does not.
// PARAMETERS
//  DEB_CYCLES  1500000  consecutive stable cycles required to accept a level change (>=2)
//  CNT_W       21       width of debounce counter; must satisfy 2**CNT_W > DEB_CYCLES
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous, active-low reset
//  btnS        in   1  raw push-button, asynchronous, may bounce
//  sw          in   8  raw instruction switches, asynchronous
//  inst_vld    out  1  one-cycle strobe: a new instruction was accepted
//  inst_wd     out  8  instruction word; valid with inst_vld, held until the next strobe
//  inst_cnt    out  8  accepted-instruction count, wraps modulo 256
//  btn_stable  out  1  debounced button level (1 = pressed)
// BEHAVIOUR
//  Reset (async assert, sync use): sync flops, cnt, inst_vld, inst_wd, inst_cnt and
//   btn_stable are all 0. State is IDLE.
//  Synchroniser: 2 flops on btnS (output b_s) and 2 flops per sw bit (output sw_s).
//   Nothing downstream uses the raw inputs.
//  FSM, all transitions on clk rising edge:
//   IDLE:    b_s=1 -> PRESS_WAIT with cnt=1. Otherwise stay, cnt=0.
//   PRESS_WAIT:
//    b_s=0 (glitch) -> IDLE, cnt=0.
//    b_s=1 and cnt==DEB_CYCLES-1 -> HELD. In the same edge: inst_vld<=1, inst_wd<=sw_s,
//     inst_cnt<=inst_cnt+1, btn_stable<=1.
//    Otherwise cnt<=cnt+1.
//   HELD:    b_s=0 -> RELEASE_WAIT with cnt=1. Otherwise stay.
//   RELEASE_WAIT:
//    b_s=1 -> HELD, cnt=0. No new strobe.
//    b_s=0 and cnt==DEB_CYCLES-1 -> IDLE, btn_stable<=0.
//    Otherwise cnt<=cnt+1.
//  inst_vld is 1 for exactly one cycle and is cleared on the following edge.
//   There is never a strobe on release.
//  Latency: take edge 1 as the first edge that samples btnS=1 and hold btnS stable.
//   inst_vld is then high in the cycle after edge DEB_CYCLES+2.
//  Re-arm: a second strobe requires a full debounced release (return to IDLE) first.
//   Holding the button produces exactly one strobe.
//  sw changes while HELD or between presses do not affect inst_wd.
//   Only the sw_s value at the HELD-entry edge is captured.
//  inst_cnt wraps 255 -> 0 with no flag.
//  Reset mid-operation: every state returns to the reset values immediately, with no
//   strobe. If btnS is still held after rst_n deasserts, it is treated as a fresh press
//   and produces one strobe after the normal latency.
// TESTING (bench sets DEB_CYCLES=4)
//  1. sw=8'h04, btnS held high for 50 cycles -> exactly one inst_vld, in the cycle
//     after edge 6. inst_wd=8'h04, inst_cnt=1.
//  2. btnS pulses high for 2 cycles then low, repeated 5 times -> no inst_vld,
//     btn_stable stays 0.
//  3. Press held; sw changes 8'h04->8'hC0 while HELD; release, re-press ->
//     first strobe inst_wd=8'h04, second strobe inst_wd=8'hC0, inst_cnt=2.
//  4. While HELD, btnS drops low for 2 cycles then returns high -> no extra strobe,
//     btn_stable stays 1.
//  5. 256 clean presses -> inst_cnt reads 8'h00 after the last one.
//     Strobe count equals press count.
//  6. rst_n asserted in PRESS_WAIT (cnt=2) with btnS still high -> all outputs 0
//     immediately. After deassert, one strobe follows after the normal latency.

Source files
------------

// File: rtl/inst_capture.sv
// inst_capture: front end of the nexys3 sequencer core.
// Synchronises btnS and the instruction switches, debounces btnS, and issues
// one single-cycle inst_vld per clean press with the switch word captured at
// the moment the press is accepted.
module inst_capture #(
    parameter int DEB_CYCLES = 1500000,
    parameter int CNT_W      = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnS,
    input  logic [7:0] sw,
    output logic       inst_vld,
    output logic [7:0] inst_wd,
    output logic [7:0] inst_cnt,
    output logic       btn_stable
);

    // Terminal count: the DEB_CYCLES-th consecutive cycle of a new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             b_m;
    logic             b_s;
    logic [7:0]       sw_m;
    logic [7:0]       sw_s;

    logic             vld_nxt;
    logic [7:0]       wd_nxt;
    logic [7:0]       icnt_nxt;
    logic             stable_nxt;

    // Two-flop synchronisers for the asynchronous button and switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_m  <= 1'b0;
            b_s  <= 1'b0;
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            b_m  <= btnS;
            b_s  <= b_m;
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            inst_vld   <= 1'b0;
            inst_wd    <= '0;
            inst_cnt   <= '0;
            btn_stable <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            inst_vld   <= vld_nxt;
            inst_wd    <= wd_nxt;
            inst_cnt   <= icnt_nxt;
            btn_stable <= stable_nxt;
        end
    end

    // Next-state logic: a level change is accepted only after DEB_CYCLES
    // consecutive cycles at the new level; any bounce restarts the wait.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        vld_nxt    = 1'b0;
        wd_nxt     = inst_wd;
        icnt_nxt   = inst_cnt;
        stable_nxt = btn_stable;

        unique case (state)
            IDLE: begin
                if (b_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!b_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = HELD;
                    cnt_nxt    = '0;
                    vld_nxt    = 1'b1;
                    wd_nxt     = sw_s;
                    icnt_nxt   = inst_cnt + 8'd1;
                    stable_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            HELD: begin
                if (!b_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (b_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    stable_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_capture.sv
// Self-checking bench for inst_capture with DEB_CYCLES=4.
// A run-length debounce model predicts every output each cycle; directed
// tests add literal expectations for latency, captured words and counts.
module tb_inst_capture;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic       btnS;
    logic [7:0] sw;
    logic       inst_vld;
    logic [7:0] inst_wd;
    logic [7:0] inst_cnt;
    logic       btn_stable;

    int checks = 0;
    int errors = 0;

    inst_capture #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnS       (btnS),
        .sw         (sw),
        .inst_vld   (inst_vld),
        .inst_wd    (inst_wd),
        .inst_cnt   (inst_cnt),
        .btn_stable (btn_stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: inputs seen two edges late; the debounced level flips after
    // DEB consecutive edges that disagree with it. A flip to 1 is a strobe.
    logic       m_b1, m_b2, m_level, m_vld;
    logic [7:0] m_sw1, m_sw2, m_wd, m_cnt;
    int         m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b1 <= 0; m_b2 <= 0; m_sw1 <= 0; m_sw2 <= 0;
            m_level <= 0; m_run <= 0; m_vld <= 0; m_wd <= 0; m_cnt <= 0;
        end else begin
            m_b1  <= btnS;
            m_b2  <= m_b1;
            m_sw1 <= sw;
            m_sw2 <= m_sw1;
            m_vld <= 0;
            if (m_b2 != m_level) begin
                if (m_run + 1 == DEB) begin
                    m_level <= m_b2;
                    m_run   <= 0;
                    if (m_b2) begin
                        m_vld <= 1;
                        m_wd  <= m_sw2;
                        m_cnt <= m_cnt + 8'd1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, plus strobe bookkeeping.
    int         strobes = 0;
    logic [7:0] wd_log[$];

    always @(negedge clk) begin
        check("inst_vld",   int'(inst_vld),   int'(m_vld));
        check("inst_wd",    int'(inst_wd),    int'(m_wd));
        check("inst_cnt",   int'(inst_cnt),   int'(m_cnt));
        check("btn_stable", int'(btn_stable), int'(m_level));
        if (inst_vld) begin
            strobes++;
            wd_log.push_back(inst_wd);
        end
    end

    // Advance n cycles; inputs then change just after a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 0; btnS = 0; sw = 0;
        tick(3);
        rst_n = 1;
        tick(3);
    endtask

    int s0;

    initial begin
        rst_n = 0; btnS = 0; sw = 0;
        tick(2);
        check("reset_vld",    int'(inst_vld),   0);
        check("reset_wd",     int'(inst_wd),    0);
        check("reset_cnt",    int'(inst_cnt),   0);
        check("reset_stable", int'(btn_stable), 0);
        rst_n = 1;
        tick(3);

        // 1: held press, strobe in the cycle after edge 6
        s0 = strobes;
        sw = 8'h04; btnS = 1;
        repeat (5) @(posedge clk);
        #1 check("t1_no_early", int'(inst_vld), 0);
        @(posedge clk);
        #1 check("t1_vld_edge6", int'(inst_vld), 1);
        check("t1_wd", int'(inst_wd), 8'h04);
        check("t1_cnt", int'(inst_cnt), 1);
        @(posedge clk);
        #1 check("t1_vld_one_cycle", int'(inst_vld), 0);
        tick(43);
        check("t1_strobes", strobes - s0, 1);
        btnS = 0;
        tick(10);

        // 2: short pulses are rejected
        do_reset();
        s0 = strobes;
        for (int i = 0; i < 5; i++) begin
            btnS = 1; tick(2);
            btnS = 0; tick(3);
        end
        tick(6);
        check("t2_strobes", strobes - s0, 0);
        check("t2_stable", int'(btn_stable), 0);

        // 3: switch change while held is captured only on the next press
        do_reset();
        s0 = strobes;
        wd_log.delete();
        sw = 8'h04; btnS = 1; tick(10);
        sw = 8'hC0;           tick(10);
        btnS = 0;             tick(10);
        btnS = 1;             tick(10);
        btnS = 0;             tick(10);
        check("t3_strobes", strobes - s0, 2);
        if (wd_log.size() == 2) begin
            check("t3_wd_first",  int'(wd_log[0]), 8'h04);
            check("t3_wd_second", int'(wd_log[1]), 8'hC0);
        end else begin
            check("t3_wd_log_size", wd_log.size(), 2);
        end
        check("t3_cnt", int'(inst_cnt), 2);

        // 4: release glitch while held
        do_reset();
        s0 = strobes;
        btnS = 1; tick(10);
        btnS = 0; tick(2);
        btnS = 1; tick(10);
        check("t4_strobes", strobes - s0, 1);
        check("t4_stable", int'(btn_stable), 1);
        btnS = 0; tick(10);
        check("t4_released", int'(btn_stable), 0);

        // 5: 256 presses wrap the counter
        do_reset();
        s0 = strobes;
        for (int i = 0; i < 256; i++) begin
            sw = 8'(i);
            btnS = 1; tick(8);
            btnS = 0; tick(8);
        end
        check("t5_strobes", strobes - s0, 256);
        check("t5_cnt_wrap", int'(inst_cnt), 0);
        check("t5_last_wd", int'(inst_wd), 8'hFF);

        // 6: reset while debouncing a press, button kept held
        sw = 8'h5A; btnS = 1; tick(10);
        btnS = 0; tick(10);
        check("t6_pre_cnt", int'(inst_cnt), 1);
        sw = 8'h81; btnS = 1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        check("t6_rst_vld",    int'(inst_vld),   0);
        check("t6_rst_wd",     int'(inst_wd),    0);
        check("t6_rst_cnt",    int'(inst_cnt),   0);
        check("t6_rst_stable", int'(btn_stable), 0);
        tick(2);
        s0 = strobes;
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1 check("t6_no_early", int'(inst_vld), 0);
        @(posedge clk);
        #1 check("t6_vld", int'(inst_vld), 1);
        check("t6_wd", int'(inst_wd), 8'h81);
        check("t6_cnt", int'(inst_cnt), 1);
        tick(10);
        check("t6_strobes", strobes - s0, 1);
        btnS = 0; tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
